// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcode and func
// encodings, the ALU operation enum and the controller state enum.
package mips_mc_pkg;

   localparam int unsigned OpcW  = 6;
   localparam int unsigned FuncW = 6;

   // Opcodes as presented on IR[31:26] by the datapath
   localparam logic [5:0] OP_RT   = 6'd0;
   localparam logic [5:0] OP_ADDI = 6'd1;
   localparam logic [5:0] OP_SLTI = 6'd2;
   localparam logic [5:0] OP_LW   = 6'd3;
   localparam logic [5:0] OP_SW   = 6'd4;
   localparam logic [5:0] OP_BEQ  = 6'd5;
   localparam logic [5:0] OP_J    = 6'd6;
   localparam logic [5:0] OP_JR   = 6'd7;
   localparam logic [5:0] OP_JAL  = 6'd8;

   // R-type func field codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ADD encodes as zero so idle/reset outputs read as a plain add
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StREx,
      StRWb,
      StIEx,
      StIWb,
      StMAddr,
      StMRd,
      StMWr,
      StLwWb,
      StBranch,
      StJump,
      StTrap
   } state_t;

endpackage

// File: rtl/mips_alu_func_decoder.sv
// Combinational R-type func -> ALU operation decode.
// Ports:
//   func       in   FUNC_W  IR[5:0]
//   operation  out  3       ALU operation; unknown func codes decode to ADD
module mips_alu_func_decoder
   import mips_mc_pkg::*;
#(
   parameter int unsigned FUNC_W = 6
) (
   input  logic [FUNC_W-1:0] func,
   output logic [2:0]        operation
);

   always_comb begin
      operation = ALU_ADD;
      case (func)
         FUNC_W'(FN_ADD): operation = ALU_ADD;
         FUNC_W'(FN_SUB): operation = ALU_SUB;
         FUNC_W'(FN_AND): operation = ALU_AND;
         FUNC_W'(FN_OR):  operation = ALU_OR;
         FUNC_W'(FN_SLT): operation = ALU_SLT;
         default:         operation = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared memory, ALU and register file, with memory
// wait-states, a memory-timeout watchdog and an illegal-opcode trap.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   opcode, func               IR[31:26], IR[5:0]
//   zero                       ALU zero flag (gates pc_write in BRANCH)
//   mem_ready                  memory completes the current access this cycle
//   pc_write, iord, mem_read, mem_write, ir_write, reg_dst, wb_sel, reg_write,
//   alu_src_a, alu_src_b, pc_src, operation   datapath controls
//   instr_done                 pulse in the last state of each retired instruction
//   trap                       sticky trap flag, cleared only by rst
// Watchdog: the Nth consecutive cycle without mem_ready in FETCH/MRD/MWR, with
// N = MEM_TIMEOUT, moves to TRAP on the following edge (mem_ready wins).
module mips_multicycle_controller
   import mips_mc_pkg::*;
#(
   parameter int unsigned OPC_W        = 6,
   parameter int unsigned FUNC_W       = 6,
   parameter int unsigned MEM_TIMEOUT  = 15,
   parameter bit          TRAP_ILLEGAL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [FUNC_W-1:0] func,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              pc_write,
   output logic              iord,
   output logic              mem_read,
   output logic              mem_write,
   output logic              ir_write,
   output logic [1:0]        reg_dst,
   output logic [1:0]        wb_sel,
   output logic              reg_write,
   output logic              alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [1:0]        pc_src,
   output logic [2:0]        operation,
   output logic              instr_done,
   output logic              trap
);

   localparam int unsigned WdW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t         state_q, state_d;
   logic [WdW-1:0] wdog_q, wdog_d;
   logic           trap_q, trap_d;
   logic [2:0]     r_op;
   logic           wdog_expired;

   mips_alu_func_decoder #(
      .FUNC_W(FUNC_W)
   ) u_func_dec (
      .func     (func),
      .operation(r_op)
   );

   // True when the current not-ready cycle is the MEM_TIMEOUT-th in a row
   assign wdog_expired = (MEM_TIMEOUT != 0) && ((32'(wdog_q) + 32'd1) >= MEM_TIMEOUT);

   always_comb begin
      state_d    = state_q;
      wdog_d     = '0;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 2'b00;
      wb_sel     = 2'b00;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      operation  = ALU_ADD;
      instr_done = 1'b0;

      unique case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (wdog_expired) begin
               state_d = StTrap;
            end else begin
               wdog_d = wdog_q + WdW'(1);
            end
         end
         StDecode: begin
            // Precompute the branch target into ALUOut
            alu_src_b = 2'b11;
            case (opcode)
               OPC_W'(OP_RT):                               state_d = StREx;
               OPC_W'(OP_ADDI), OPC_W'(OP_SLTI):            state_d = StIEx;
               OPC_W'(OP_LW), OPC_W'(OP_SW):                state_d = StMAddr;
               OPC_W'(OP_BEQ):                              state_d = StBranch;
               OPC_W'(OP_J), OPC_W'(OP_JR), OPC_W'(OP_JAL): state_d = StJump;
               default: begin
                  if (TRAP_ILLEGAL) begin
                     state_d = StTrap;
                  end else begin
                     state_d    = StFetch;
                     instr_done = 1'b1;
                  end
               end
            endcase
         end
         StREx: begin
            alu_src_a = 1'b1;
            operation = r_op;
            state_d   = StRWb;
         end
         StRWb: begin
            reg_dst    = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StIEx: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            operation = (opcode == OPC_W'(OP_SLTI)) ? ALU_SLT : ALU_ADD;
            state_d   = StIWb;
         end
         StIWb: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StMAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OPC_W'(OP_SW)) ? StMWr : StMRd;
         end
         StMRd: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               state_d = StLwWb;
            end else if (wdog_expired) begin
               state_d = StTrap;
            end else begin
               wdog_d = wdog_q + WdW'(1);
            end
         end
         StMWr: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = StFetch;
            end else if (wdog_expired) begin
               state_d = StTrap;
            end else begin
               wdog_d = wdog_q + WdW'(1);
            end
         end
         StLwWb: begin
            wb_sel     = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StBranch: begin
            alu_src_a  = 1'b1;
            operation  = ALU_SUB;
            pc_src     = 2'b01;
            pc_write   = zero;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StJump: begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
            pc_src     = (opcode == OPC_W'(OP_JR)) ? 2'b11 : 2'b10;
            if (opcode == OPC_W'(OP_JAL)) begin
               reg_dst   = 2'b10;
               wb_sel    = 2'b10;
               reg_write = 1'b1;
            end
            state_d = StFetch;
         end
         StTrap: begin
            state_d = StTrap;
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      trap_d = trap_q | (state_d == StTrap);

      // Reset dominates every output, whatever the registered state holds
      if (rst) begin
         pc_write   = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_dst    = 2'b00;
         wb_sel     = 2'b00;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         pc_src     = 2'b00;
         operation  = ALU_ADD;
         instr_done = 1'b0;
      end
   end

   assign trap = trap_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         wdog_q  <= '0;
         trap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         trap_q  <= trap_d;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: each cycle applies inputs and
// compares the full packed control word against a hand-written expectation.
module tb_mips_multicycle_controller;
   import mips_mc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] func;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
   logic       instr_done, trap;
   logic [1:0] reg_dst, wb_sel, alu_src_b, pc_src;
   logic [2:0] operation;
   logic [19:0] obs;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mips_multicycle_controller #(
      .OPC_W       (6),
      .FUNC_W      (6),
      .MEM_TIMEOUT (15),
      .TRAP_ILLEGAL(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .func      (func),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_write  (pc_write),
      .iord      (iord),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .ir_write  (ir_write),
      .reg_dst   (reg_dst),
      .wb_sel    (wb_sel),
      .reg_write (reg_write),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .pc_src    (pc_src),
      .operation (operation),
      .instr_done(instr_done),
      .trap      (trap)
   );

   assign obs = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, wb_sel, reg_write,
                 alu_src_a, alu_src_b, pc_src, operation, instr_done, trap};

   // Packs expected controls in the same order as obs
   function automatic logic [19:0] ov(input logic pcw, io, mr, mw, irw,
                                      input logic [1:0] rd, wb, input logic rw, sa,
                                      input logic [1:0] sb, ps, input logic [2:0] op,
                                      input logic done, tr);
      return {pcw, io, mr, mw, irw, rd, wb, rw, sa, sb, ps, op, done, tr};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs, advance past the next edge
   task automatic cyc(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                      input logic z, input logic rdy, input logic [19:0] exp);
      opcode    = opc;
      func      = fn;
      zero      = z;
      mem_ready = rdy;
      #1;
      check_eq(tag, 32'(obs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      opcode    = OP_LW;
      func      = FN_ADD;
      zero      = 1'b1;
      mem_ready = 1'b1;
      #1;
      check_eq("rst_async_view", 32'(obs), 32'(0));
      @(posedge clk);
      #1;
      check_eq("rst_hold_a", 32'(obs), 32'(0));
      @(posedge clk);
      #1;
      check_eq("rst_hold_b", 32'(obs), 32'(0));
      rst = 1'b0;
   endtask

   logic [19:0] v_fetch, v_fwait, v_dec, v_rwb, v_iwb, v_maddr, v_mrd, v_lwwb;
   logic [19:0] v_mwr_w, v_mwr_d, v_trap, v_j, v_jr, v_jal;
   logic [5:0]  fns [6];
   logic [2:0]  ops [6];

   initial begin
      v_fetch = ov(1, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, ALU_ADD, 0, 0);
      v_fwait = ov(0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, ALU_ADD, 0, 0);
      v_dec   = ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, ALU_ADD, 0, 0);
      v_rwb   = ov(0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, ALU_ADD, 1, 0);
      v_iwb   = ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, ALU_ADD, 1, 0);
      v_maddr = ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, ALU_ADD, 0, 0);
      v_mrd   = ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, ALU_ADD, 0, 0);
      v_lwwb  = ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, ALU_ADD, 1, 0);
      v_mwr_w = ov(0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, ALU_ADD, 0, 0);
      v_mwr_d = ov(0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, ALU_ADD, 1, 0);
      v_trap  = ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, ALU_ADD, 0, 1);
      v_j     = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b10, ALU_ADD, 1, 0);
      v_jr    = ov(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, ALU_ADD, 1, 0);
      v_jal   = ov(1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 2'b10, ALU_ADD, 1, 0);
      fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b000111};
      ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ADD};

      do_reset();

      // R-type for every func code plus one unknown code (decodes to ADD)
      for (int i = 0; i < 6; i++) begin
         cyc("r_fetch", OP_RT, fns[i], 0, 1, v_fetch);
         cyc("r_decode", OP_RT, fns[i], 0, 1, v_dec);
         cyc("r_ex", OP_RT, fns[i], 0, 1,
             ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, ops[i], 0, 0));
         cyc("r_wb", OP_RT, fns[i], 0, 1, v_rwb);
      end

      // addi / slti
      cyc("addi_fetch", OP_ADDI, 6'd0, 0, 1, v_fetch);
      cyc("addi_decode", OP_ADDI, 6'd0, 0, 1, v_dec);
      cyc("addi_ex", OP_ADDI, 6'd0, 0, 1,
          ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, ALU_ADD, 0, 0));
      cyc("addi_wb", OP_ADDI, 6'd0, 0, 1, v_iwb);
      cyc("slti_fetch", OP_SLTI, 6'd0, 0, 1, v_fetch);
      cyc("slti_decode", OP_SLTI, 6'd0, 0, 1, v_dec);
      cyc("slti_ex", OP_SLTI, 6'd0, 0, 1,
          ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, ALU_SLT, 0, 0));
      cyc("slti_wb", OP_SLTI, 6'd0, 0, 1, v_iwb);

      // lw with three wait-states in MRD: 8 cycles total
      cyc("lw_fetch", OP_LW, 6'd0, 0, 1, v_fetch);
      cyc("lw_decode", OP_LW, 6'd0, 0, 1, v_dec);
      cyc("lw_maddr", OP_LW, 6'd0, 0, 1, v_maddr);
      for (int i = 0; i < 3; i++) cyc("lw_mrd_wait", OP_LW, 6'd0, 0, 0, v_mrd);
      cyc("lw_mrd_ready", OP_LW, 6'd0, 0, 1, v_mrd);
      cyc("lw_wb", OP_LW, 6'd0, 0, 1, v_lwwb);

      // sw with one wait-state
      cyc("sw_fetch", OP_SW, 6'd0, 0, 1, v_fetch);
      cyc("sw_decode", OP_SW, 6'd0, 0, 1, v_dec);
      cyc("sw_maddr", OP_SW, 6'd0, 0, 1, v_maddr);
      cyc("sw_mwr_wait", OP_SW, 6'd0, 0, 0, v_mwr_w);
      cyc("sw_mwr_done", OP_SW, 6'd0, 0, 1, v_mwr_d);

      // beq taken and not taken
      for (int z = 1; z >= 0; z--) begin
         cyc("beq_fetch", OP_BEQ, 6'd0, z[0], 1, v_fetch);
         cyc("beq_decode", OP_BEQ, 6'd0, z[0], 1, v_dec);
         cyc("beq_branch", OP_BEQ, 6'd0, z[0], 1,
             ov(z[0], 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, ALU_SUB, 1, 0));
      end

      // j / jr / jal
      cyc("j_fetch", OP_J, 6'd0, 0, 1, v_fetch);
      cyc("j_decode", OP_J, 6'd0, 0, 1, v_dec);
      cyc("j_jump", OP_J, 6'd0, 0, 1, v_j);
      cyc("jr_fetch", OP_JR, 6'd0, 0, 1, v_fetch);
      cyc("jr_decode", OP_JR, 6'd0, 0, 1, v_dec);
      cyc("jr_jump", OP_JR, 6'd0, 0, 1, v_jr);
      cyc("jal_fetch", OP_JAL, 6'd0, 0, 1, v_fetch);
      cyc("jal_decode", OP_JAL, 6'd0, 0, 1, v_dec);
      cyc("jal_jump", OP_JAL, 6'd0, 0, 1, v_jal);

      // Fetch wait-states, then an illegal opcode traps after DECODE
      cyc("ill_fetch_wait", 6'h3F, 6'd0, 0, 0, v_fwait);
      cyc("ill_fetch_wait", 6'h3F, 6'd0, 0, 0, v_fwait);
      cyc("ill_fetch", 6'h3F, 6'd0, 0, 1, v_fetch);
      cyc("ill_decode", 6'h3F, 6'd0, 0, 1, v_dec);
      for (int i = 0; i < 20; i++) cyc("ill_trap_hold", OP_RT, FN_ADD, 1, 1, v_trap);

      // Reset clears the trap
      do_reset();
      cyc("post_trap_fetch", OP_RT, FN_ADD, 0, 1, v_fetch);
      cyc("post_trap_decode", OP_RT, FN_ADD, 0, 1, v_dec);
      cyc("post_trap_rex", OP_RT, FN_ADD, 0, 1,
          ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, ALU_ADD, 0, 0));
      cyc("post_trap_rwb", OP_RT, FN_ADD, 0, 1, v_rwb);

      // mem_ready on the timeout cycle wins: 14 waits then ready
      for (int i = 0; i < 14; i++) cyc("wd_edge_wait", OP_J, 6'd0, 0, 0, v_fwait);
      cyc("wd_edge_ready", OP_J, 6'd0, 0, 1, v_fetch);
      cyc("wd_edge_decode", OP_J, 6'd0, 0, 1, v_dec);
      cyc("wd_edge_jump", OP_J, 6'd0, 0, 1, v_j);

      // 15 consecutive not-ready FETCH cycles -> TRAP
      for (int i = 0; i < 15; i++) cyc("wd_wait", OP_J, 6'd0, 0, 0, v_fwait);
      for (int i = 0; i < 5; i++) cyc("wd_trap_hold", OP_J, 6'd0, 0, 1, v_trap);

      // Reset also wins while trapped
      do_reset();
      cyc("final_fetch", OP_RT, FN_ADD, 0, 1, v_fetch);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
